// File: rtl/csr_tx_fifo.sv
// csr_tx_fifo: CSR-fed transmit FIFO in front of the UART transmitter.
// Software pushes one entry per write to DataCsrAddr. The consumer pops
// through out_valid/out_ready. Bulk storage is a simple dual-port RAM.
// A two-entry register head stage is prefetched from that RAM, which gives
// first-word-fall-through output with no bubbles while count > 1.
// Optional feature macro: CSR_TX_FIFO_STATUS_EN adds a readable status CSR
// with a sticky overflow flag. Without it, the status address is a no-op
// and reads as zero.
module csr_tx_fifo #(
   parameter int unsigned DataWidth     = 8,
   parameter int unsigned Depth         = 16,
   parameter logic [11:0] DataCsrAddr   = 12'h7C0,  // FIFO byte CSR
   parameter logic [11:0] StatusCsrAddr = 12'h7C1   // FIFO status CSR
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         csr_enable,
   input  logic [11:0]                  csr_addr,
   input  logic [2:0]                   csr_op,
   input  logic [31:0]                  rs1_data,
   output logic [31:0]                  csr_data_out,
   output logic [DataWidth-1:0]         out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         full,
   output logic [$clog2(Depth+1)-1:0]   count
);

   localparam int unsigned CW = $clog2(Depth + 1);
   localparam int unsigned PW = $clog2(Depth);
   localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

   // CSR operation encodings (RISC-V funct3)
   localparam logic [2:0] OP_RW  = 3'b001;
   localparam logic [2:0] OP_RS  = 3'b010;
   localparam logic [2:0] OP_RC  = 3'b011;
   localparam logic [2:0] OP_RWI = 3'b101;
   localparam logic [2:0] OP_RSI = 3'b110;
   localparam logic [2:0] OP_RCI = 3'b111;

   logic [DataWidth-1:0] r_mem [Depth];
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_ram_cnt;
   logic [CW-1:0]        r_count;
   logic                 r_full;
   logic [DataWidth-1:0] r_h0;
   logic [DataWidth-1:0] r_h1;
   logic                 r_v0;
   logic                 r_v1;

   logic                 w_is_write;
   logic                 w_push_req;
   logic                 w_full_now;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_rd;
   logic [DataWidth-1:0] w_rd_data;
   logic [DataWidth-1:0] w_h0_n;
   logic [DataWidth-1:0] w_h1_n;
   logic                 w_v0_n;
   logic                 w_v1_n;
   logic [CW-1:0]        w_count_n;
   logic [CW-1:0]        w_ram_cnt_n;

   // Decide whether the CSR op writes; set/clear forms write only with a non-zero operand
   always_comb begin
      w_is_write = 1'b0;
      case (csr_op)
         OP_RW, OP_RWI:                  w_is_write = 1'b1;
         OP_RS, OP_RC, OP_RSI, OP_RCI:   w_is_write = (rs1_data != 32'h0);
         default:                        w_is_write = 1'b0;
      endcase
   end

   assign w_push_req = csr_enable && (csr_addr == DataCsrAddr) && w_is_write;
   assign w_full_now = (r_count == DEPTH_C);
   // A push at full is dropped even when a pop happens in the same cycle
   assign w_push     = w_push_req && !w_full_now;
   assign w_pop      = r_v0 && out_ready;
   // Prefetch when the RAM holds a committed entry and the head has a free slot after this pop
   assign w_rd       = (r_ram_cnt != {CW{1'b0}}) && !(r_v1 && !w_pop);
   assign w_rd_data  = r_mem[r_rd_ptr];

   // Head stage next state: shift on pop, then append the prefetched RAM word
   always_comb begin
      w_h0_n = r_h0;
      w_h1_n = r_h1;
      w_v0_n = r_v0;
      w_v1_n = r_v1;
      if (w_pop) begin
         w_h0_n = r_h1;
         w_v0_n = r_v1;
         w_h1_n = {DataWidth{1'b0}};
         w_v1_n = 1'b0;
      end else begin
         w_h0_n = r_h0;
         w_v0_n = r_v0;
      end
      if (w_rd) begin
         if (!w_v0_n) begin
            w_h0_n = w_rd_data;
            w_v0_n = 1'b1;
         end else begin
            w_h1_n = w_rd_data;
            w_v1_n = 1'b1;
         end
      end else begin
         w_v1_n = w_v1_n;
      end
      if (!w_v0_n) begin
         w_h0_n = {DataWidth{1'b0}};
      end else begin
         w_h0_n = w_h0_n;
      end
   end

   // Occupancy arithmetic for total count and RAM-resident entries
   always_comb begin
      w_count_n   = r_count;
      w_ram_cnt_n = r_ram_cnt;
      case ({w_push, w_pop})
         2'b10:   w_count_n = r_count + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   w_count_n = r_count - {{(CW-1){1'b0}}, 1'b1};
         default: w_count_n = r_count;
      endcase
      case ({w_push, w_rd})
         2'b10:   w_ram_cnt_n = r_ram_cnt + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   w_ram_cnt_n = r_ram_cnt - {{(CW-1){1'b0}}, 1'b1};
         default: w_ram_cnt_n = r_ram_cnt;
      endcase
   end

   // Bulk storage write port; contents need no reset because occupancy tracks validity
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rs1_data[DataWidth-1:0];
      end
   end

   // Pointers, counters and head-stage registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_wr_ptr  <= {PW{1'b0}};
         r_rd_ptr  <= {PW{1'b0}};
         r_ram_cnt <= {CW{1'b0}};
         r_count   <= {CW{1'b0}};
         r_full    <= 1'b0;
         r_h0      <= {DataWidth{1'b0}};
         r_h1      <= {DataWidth{1'b0}};
         r_v0      <= 1'b0;
         r_v1      <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1'b1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PW'(1'b1);
         end
         r_ram_cnt <= w_ram_cnt_n;
         r_count   <= w_count_n;
         r_full    <= (w_count_n == DEPTH_C);
         r_h0      <= w_h0_n;
         r_h1      <= w_h1_n;
         r_v0      <= w_v0_n;
         r_v1      <= w_v1_n;
      end
   end

   assign out_data  = r_h0;
   assign out_valid = r_v0;
   assign count     = r_count;
   assign full      = r_full;

`ifdef CSR_TX_FIFO_STATUS_EN
   logic        r_overflow;
   logic        w_status_acc;
   logic        w_ovf_clr;
   logic [31:0] w_status;

   assign w_status_acc = csr_enable && (csr_addr == StatusCsrAddr);
   assign w_ovf_clr    = w_status_acc && rs1_data[31] &&
                         ((csr_op == OP_RW) || (csr_op == OP_RC));

   // Sticky overflow: a dropped push sets it, a status write of bit 31 clears it, set wins
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_overflow <= 1'b0;
      end else if (w_push_req && w_full_now) begin
         r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= r_overflow;
      end
   end

   // Status read data, driven only during a status access
   always_comb begin
      w_status         = 32'h0;
      w_status[31]     = r_overflow;
      w_status[30]     = r_full;
      w_status[29]     = !r_v0;
      w_status[CW-1:0] = r_count;
      if (w_status_acc) begin
         csr_data_out = w_status;
      end else begin
         csr_data_out = 32'h0;
      end
   end
`else
   // Status address is decoded nowhere in this build
   logic w_unused_status;
   assign w_unused_status = (csr_addr == StatusCsrAddr);
   assign csr_data_out    = 32'h0;
`endif

endmodule

// File: tb/tb_csr_tx_fifo.sv
// Directed testbench for csr_tx_fifo (Depth=16, DataWidth=8).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_csr_tx_fifo;

   localparam logic [11:0] DATA_A = 12'h7C0;
   localparam logic [11:0] STAT_A = 12'h7C1;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        csr_enable;
   logic [11:0] csr_addr;
   logic [2:0]  csr_op;
   logic [31:0] rs1_data;
   logic [31:0] csr_data_out;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        full;
   logic [4:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   csr_tx_fifo #(
      .DataWidth(8), .Depth(16), .DataCsrAddr(DATA_A), .StatusCsrAddr(STAT_A)
   ) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .csr_enable(csr_enable),
      .csr_addr(csr_addr), .csr_op(csr_op), .rs1_data(rs1_data),
      .csr_data_out(csr_data_out), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .full(full), .count(count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic csr_idle();
      csr_enable = 1'b0;
      csr_addr   = 12'h000;
      csr_op     = 3'b000;
      rs1_data   = 32'h0;
   endtask

   task automatic set_push(input logic [7:0] d);
      csr_enable = 1'b1;
      csr_addr   = DATA_A;
      csr_op     = 3'b001;
      rs1_data   = {24'h0, d};
   endtask

   // Expected status word; zero when the status feature is compiled out
   function automatic logic [31:0] st(input logic ovf, input logic fl, input logic emp, input int cnt);
      logic [31:0] v;
      v = {ovf, fl, emp, 24'h0, cnt[4:0]};
`ifndef CSR_TX_FIFO_STATUS_EN
      v = 32'h0;
`endif
      return v;
   endfunction

   task automatic read_status(input string tag, input logic [31:0] exp_st);
      csr_enable = 1'b1;
      csr_addr   = STAT_A;
      csr_op     = 3'b010;
      rs1_data   = 32'h0;
      #1;
      check_val(tag, csr_data_out, exp_st);
      csr_idle();
   endtask

   task automatic clear_ovf(input logic [2:0] op);
      csr_enable = 1'b1;
      csr_addr   = STAT_A;
      csr_op     = op;
      rs1_data   = 32'h8000_0000;
      tick();
      csr_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] bp_exp [4];
      logic [7:0] exp_q [$];
      logic [7:0] d;
      int mcount;
      int pushed;
      int cyc;
      bit do_push;
      bit rdy;

      reset_ni  = 1'b0;
      out_ready = 1'b0;
      csr_idle();
      #12;
      check_val("rst_count", count, 32'd0);
      check_val("rst_valid", out_valid, 32'd0);
      check_val("rst_data", out_data, 32'h0);
      check_val("rst_full", full, 32'd0);
      check_val("rst_csr_out", csr_data_out, 32'h0);
      read_status("rst_status", st(1'b0, 1'b0, 1'b1, 0));
      #1;
      reset_ni = 1'b1;
      tick();

      // Reset mid-stream
      for (int i = 0; i < 5; i++) begin
         set_push(8'h10 + 8'(i));
         tick();
         csr_idle();
      end
      check_val("pre_rst_count", count, 32'd5);
      #3;
      reset_ni = 1'b0;
      #1;
      check_val("mid_rst_count", count, 32'd0);
      check_val("mid_rst_valid", out_valid, 32'd0);
      #2;
      reset_ni = 1'b1;
      tick();
      set_push(8'hA5);
      tick();
      csr_idle();
      tick();
      check_val("a5_valid", out_valid, 32'd1);
      check_val("a5_data", out_data, 32'hA5);
      check_val("a5_count", count, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_val("a5_pop_count", count, 32'd0);
      check_val("a5_pop_valid", out_valid, 32'd0);

      // Fill to full with backpressure
      for (int i = 0; i < 16; i++) begin
         set_push(8'(i));
         tick();
         csr_idle();
      end
      check_val("fill_count", count, 32'd16);
      check_val("fill_full", full, 32'd1);
      check_val("fill_valid", out_valid, 32'd1);
      check_val("fill_head", out_data, 32'h00);

      // Overflow at full
      set_push(8'h55);
      tick();
      csr_idle();
      check_val("ovf_count", count, 32'd16);
      check_val("ovf_full", full, 32'd1);
      check_val("ovf_head", out_data, 32'h00);
      read_status("ovf_status", st(1'b1, 1'b1, 1'b0, 16));
      clear_ovf(3'b001);
      read_status("ovf_clr_rw", st(1'b0, 1'b1, 1'b0, 16));

      // Drain, with a push of 0x77 colliding with the first pop at full
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check_val("drain_valid", out_valid, 32'd1);
         check_val("drain_data", out_data, 32'(i));
         if (i == 0) begin
            set_push(8'h77);
         end
         tick();
         csr_idle();
         if (i == 0) begin
            check_val("pp_full_count", count, 32'd15);
            check_val("pp_full_flag", full, 32'd0);
         end
      end
      out_ready = 1'b0;
      check_val("drain_end_valid", out_valid, 32'd0);
      check_val("drain_end_count", count, 32'd0);
      read_status("pp_ovf_status", st(1'b1, 1'b0, 1'b1, 0));
      clear_ovf(3'b011);
      read_status("ovf_clr_rc", st(1'b0, 1'b0, 1'b1, 0));

      // Backpressure: head held for 10 cycles while 3 more entries arrive
      set_push(8'h11);
      tick();
      csr_idle();
      tick();
      check_val("bp_head_valid", out_valid, 32'd1);
      check_val("bp_head_data", out_data, 32'h11);
      for (int i = 0; i < 10; i++) begin
         if (i < 3) begin
            set_push(8'h22 + 8'(8'h11 * i));
         end else begin
            csr_idle();
         end
         tick();
         csr_idle();
         check_val("bp_stable_data", out_data, 32'h11);
         check_val("bp_stable_valid", out_valid, 32'd1);
      end
      check_val("bp_count", count, 32'd4);
      bp_exp[0] = 8'h11; bp_exp[1] = 8'h22; bp_exp[2] = 8'h33; bp_exp[3] = 8'h44;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_val("bp_drain", out_data, 32'(bp_exp[i]));
         tick();
      end
      out_ready = 1'b0;
      check_val("bp_drain_count", count, 32'd0);

      // Wrap: 40 interleaved pushes/pops with a scoreboard
      mcount = 0;
      pushed = 0;
      cyc    = 0;
      while ((pushed < 40 || exp_q.size() != 0) && cyc < 300) begin
         do_push = (pushed < 40) && ((cyc % 3) != 2);
         rdy     = (pushed >= 40) ? 1'b1 : ((cyc % 3) != 0);
         if (mcount > 1) begin
            check_val("wrap_no_gap", out_valid, 32'd1);
         end
         check_val("wrap_count", count, 32'(mcount));
         out_ready = rdy;
         if (out_valid && rdy) begin
            if (exp_q.size() == 0) begin
               check_val("wrap_extra", 32'(exp_q.size()), 32'd1);
            end else begin
               check_val("wrap_data", out_data, 32'(exp_q.pop_front()));
               mcount--;
            end
         end
         if (do_push) begin
            d = 8'(8'h80 + pushed * 7);
            set_push(d);
            exp_q.push_back(d);
            pushed++;
            mcount++;
         end
         tick();
         csr_idle();
         cyc++;
      end
      out_ready = 1'b0;
      check_val("wrap_done", 32'(exp_q.size()), 32'd0);
      check_val("wrap_end_count", count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
